// File: rtl/puf_challenge_sequencer.sv
// Sequences clear/run/capture races on one PUF subblock and assembles RESP_BITS results into a response word.
// Optional build macro PUF_SEQ_MAJORITY_EN: race each challenge three times and store the majority bit.
module puf_challenge_sequencer #(
   parameter int RESP_BITS      = 16,
   parameter int CLEAR_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [7:0]           challenge_base,
   input  logic                 puf_out,
   input  logic                 puf_done,
   output logic [7:0]           puf_challenge,
   output logic [31:0]          puf_enable,
   output logic                 puf_reset,
   output logic [RESP_BITS-1:0] response,
   output logic                 resp_valid,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam int CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(RESP_BITS - 1);
   localparam logic [CLR_W-1:0]  LAST_CLR  = CLR_W'(CLEAR_CYCLES - 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      CAPTURE,
      DONE
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [CLR_W-1:0]  clear_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              race_bit;
   logic              race_to;
   logic              done_s1, done_s2;
   logic              out_s1, out_s2;
   logic              last_race;
   logic              voted_bit;

   // Both subblock outputs are asynchronous to clock; done and out are aligned by using equal-depth chains.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         done_s1 <= 1'b0;
         done_s2 <= 1'b0;
         out_s1  <= 1'b0;
         out_s2  <= 1'b0;
      end else begin
         done_s1 <= puf_done;
         done_s2 <= done_s1;
         out_s1  <= puf_out;
         out_s2  <= out_s1;
      end
   end

`ifdef PUF_SEQ_MAJORITY_EN
   logic [1:0] race_cnt;
   logic [1:0] vote_cnt;

   // A timed-out race has race_bit forced to 0, so it votes as a zero.
   assign last_race = (race_cnt == 2'd2);
   assign voted_bit = ((vote_cnt + {1'b0, race_bit}) >= 2'd2);
`else
   assign last_race = 1'b1;
   assign voted_bit = race_bit;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         idx           <= '0;
         clear_cnt     <= '0;
         wait_cnt      <= '0;
         race_bit      <= 1'b0;
         race_to       <= 1'b0;
         puf_challenge <= 8'h00;
         puf_enable    <= 32'h0000_0000;
         puf_reset     <= 1'b1;
         response      <= '0;
         resp_valid    <= 1'b0;
         busy          <= 1'b0;
         timeout_err   <= 1'b0;
`ifdef PUF_SEQ_MAJORITY_EN
         race_cnt      <= 2'd0;
         vote_cnt      <= 2'd0;
`endif
      end else begin
         resp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               puf_reset  <= 1'b1;
               puf_enable <= 32'h0000_0000;
               if (start) begin
                  idx           <= '0;
                  response      <= '0;
                  timeout_err   <= 1'b0;
                  puf_challenge <= challenge_base;
                  clear_cnt     <= '0;
                  busy          <= 1'b1;
                  state         <= CLEAR;
`ifdef PUF_SEQ_MAJORITY_EN
                  race_cnt      <= 2'd0;
                  vote_cnt      <= 2'd0;
`endif
               end
            end

            CLEAR: begin
               if (clear_cnt == LAST_CLR) begin
                  puf_enable <= 32'hFFFF_FFFF;
                  puf_reset  <= 1'b0;
                  wait_cnt   <= '0;
                  state      <= RUN;
               end else begin
                  clear_cnt <= clear_cnt + 1'b1;
               end
            end

            // Outputs go to their CAPTURE values here so they are registered on the state change.
            RUN: begin
               if (done_s2) begin
                  race_bit   <= out_s2;
                  race_to    <= 1'b0;
                  puf_enable <= 32'h0000_0000;
                  state      <= CAPTURE;
               end else if (wait_cnt == LAST_WAIT) begin
                  race_bit   <= 1'b0;
                  race_to    <= 1'b1;
                  puf_enable <= 32'h0000_0000;
                  state      <= CAPTURE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            CAPTURE: begin
               if (race_to) begin
                  timeout_err <= 1'b1;
               end
               if (!last_race) begin
`ifdef PUF_SEQ_MAJORITY_EN
                  race_cnt <= race_cnt + 2'd1;
                  vote_cnt <= vote_cnt + {1'b0, race_bit};
`endif
                  clear_cnt <= '0;
                  puf_reset <= 1'b1;
                  state     <= CLEAR;
               end else begin
                  response[idx] <= voted_bit;
`ifdef PUF_SEQ_MAJORITY_EN
                  race_cnt      <= 2'd0;
                  vote_cnt      <= 2'd0;
`endif
                  puf_reset     <= 1'b1;
                  if (idx == LAST_IDX) begin
                     resp_valid <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx           <= idx + 1'b1;
                     puf_challenge <= puf_challenge + 8'd1;
                     clear_cnt     <= '0;
                     state         <= CLEAR;
                  end
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed self-checking bench for puf_challenge_sequencer with a behavioural PUF subblock model.
// Also covers the PUF_SEQ_MAJORITY_EN build when that macro is defined.
module tb_puf_challenge_sequencer;

`ifdef PUF_SEQ_MAJORITY_EN
   localparam int RACES = 3;
`else
   localparam int RACES = 1;
`endif

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  challenge_base;
   logic        puf_out;
   logic        puf_done;
   logic [7:0]  puf_challenge;
   logic [31:0] puf_enable;
   logic        puf_reset;
   logic [15:0] response;
   logic        resp_valid;
   logic        busy;
   logic        timeout_err;

   int errors = 0;
   int checks = 0;

   logic       hang_en;
   logic [7:0] hang_chal;
   logic       maj_en;
   int         en_cnt;

   logic [7:0] chal_log [64];
   int         clr_log [64];
   int         run_entries;
   int         run10;
   int         run_cur;
   int         hang_len;
   int         clr_run;
   int         valid_cnt;
   bit         prev_full;

   puf_challenge_sequencer #(
      .RESP_BITS(16),
      .CLEAR_CYCLES(4),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .challenge_base(challenge_base),
      .puf_out(puf_out),
      .puf_done(puf_done),
      .puf_challenge(puf_challenge),
      .puf_enable(puf_enable),
      .puf_reset(puf_reset),
      .response(response),
      .resp_valid(resp_valid),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Subblock model: done rises 20 cycles after full enable, out = challenge LSB unless overridden.
   initial begin
      puf_done = 1'b0;
      puf_out  = 1'b0;
      en_cnt   = 0;
   end
   always @(posedge clock) begin
      if (puf_enable != 32'hFFFF_FFFF || puf_reset) begin
         en_cnt   <= 0;
         puf_done <= 1'b0;
      end else begin
         en_cnt <= en_cnt + 1;
         if (en_cnt == 19 && !(hang_en && puf_challenge == hang_chal)) begin
            puf_done <= 1'b1;
            puf_out  <= (maj_en && puf_challenge == 8'h10) ? (run10 != 2) : puf_challenge[0];
         end
      end
   end

   // Observes race entries, clear-phase lengths, RUN dwell of the hung challenge and valid pulses.
   always @(negedge clock) begin
      if (puf_enable == 32'hFFFF_FFFF) begin
         if (!prev_full) begin
            if (run_entries < 64) begin
               chal_log[run_entries] = puf_challenge;
               clr_log[run_entries]  = clr_run;
            end
            run_entries++;
            if (puf_challenge == 8'h10) run10++;
            run_cur = 0;
         end
         run_cur++;
      end else if (prev_full && hang_en && puf_challenge == hang_chal) begin
         hang_len = run_cur;
      end
      prev_full = (puf_enable == 32'hFFFF_FFFF);
      if (!busy || !puf_reset) clr_run = 0;
      else clr_run++;
      if (resp_valid) valid_cnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clearLogs();
      run_entries = 0;
      run10       = 0;
      hang_len    = 0;
      valid_cnt   = 0;
   endtask

   task automatic applyStimulus(input logic [7:0] base);
      start          = 1'b1;
      challenge_base = base;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic waitValid(input int max_cycles);
      int n = 0;
      while (!resp_valid && n < max_cycles) begin
         @(negedge clock);
         n++;
      end
      checkOutput("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
   endtask

   task automatic waitRun(input int max_cycles);
      int n = 0;
      while (puf_enable != 32'hFFFF_FFFF && n < max_cycles) begin
         @(negedge clock);
         n++;
      end
      checkOutput("run_seen", puf_enable, 32'hFFFF_FFFF);
   endtask

   task automatic waitEntries(input int count, input int max_cycles);
      int n = 0;
      while (run_entries <= count && n < max_cycles) begin
         @(negedge clock);
         n++;
      end
      checkOutput("entries_seen", {31'b0, run_entries > count}, 32'd1);
   endtask

   initial begin
      reset          = 1'b0;
      start          = 1'b0;
      challenge_base = 8'h00;
      hang_en        = 1'b0;
      hang_chal      = 8'h00;
      maj_en         = 1'b0;
      run_cur        = 0;
      clr_run        = 0;
      prev_full      = 1'b0;
      clearLogs();
      repeat (3) @(negedge clock);

      checkOutput("rst_puf_reset", {31'b0, puf_reset}, 32'd1);
      checkOutput("rst_enable", puf_enable, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_response", {16'b0, response}, 32'd0);
      checkOutput("rst_valid", {31'b0, resp_valid}, 32'd0);
      checkOutput("rst_tmo", {31'b0, timeout_err}, 32'd0);
      checkOutput("rst_chal", {24'b0, puf_challenge}, 32'd0);

      reset = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("idle_busy", {31'b0, busy}, 32'd0);
      checkOutput("idle_puf_reset", {31'b0, puf_reset}, 32'd1);

      $display("[TB] sequence base 0x10 with start pulsed during RUN");
      clearLogs();
      applyStimulus(8'h10);
      checkOutput("seq1_busy", {31'b0, busy}, 32'd1);
      waitRun(200);
      start          = 1'b1;
      challenge_base = 8'h55;
      @(negedge clock);
      start = 1'b0;
      waitValid(5000);
      checkOutput("seq1_resp", {16'b0, response}, 32'h0000_AAAA);
      checkOutput("seq1_tmo", {31'b0, timeout_err}, 32'd0);
      checkOutput("seq1_entries", run_entries, 16 * RACES);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("seq1_chal%0d", i), {24'b0, chal_log[i*RACES]}, 32'h10 + i);
      end
      for (int j = 0; j < 16 * RACES; j++) begin
         checkOutput($sformatf("seq1_clr%0d", j), clr_log[j], 32'd4);
      end

      $display("[TB] start in DONE cycle, then in first IDLE cycle");
      start          = 1'b1;
      challenge_base = 8'h33;
      @(negedge clock);
      checkOutput("done_start_busy", {31'b0, busy}, 32'd0);
      checkOutput("done_start_resp", {16'b0, response}, 32'h0000_AAAA);
      checkOutput("seq1_valid_cnt", valid_cnt, 32'd1);
      clearLogs();
      challenge_base = 8'hF8;
      @(negedge clock);
      start = 1'b0;
      checkOutput("idle_start_busy", {31'b0, busy}, 32'd1);
      checkOutput("idle_start_clear", {16'b0, response}, 32'd0);
      waitValid(5000);
      checkOutput("seq2_resp", {16'b0, response}, 32'h0000_AAAA);
      for (int i = 0; i < 16; i++) begin
         logic [7:0] exp_chal;
         exp_chal = 8'hF8 + 8'(i);
         checkOutput($sformatf("seq2_chal%0d", i), {24'b0, chal_log[i*RACES]}, {24'b0, exp_chal});
      end
      repeat (2) @(negedge clock);
      checkOutput("seq2_valid_cnt", valid_cnt, 32'd1);

      $display("[TB] timeout on challenge 0x13");
      clearLogs();
      hang_en   = 1'b1;
      hang_chal = 8'h13;
      applyStimulus(8'h10);
      waitValid(8000);
      checkOutput("tmo_resp", {16'b0, response}, 32'h0000_AAA2);
      checkOutput("tmo_flag", {31'b0, timeout_err}, 32'd1);
      checkOutput("tmo_dwell", hang_len, 32'd64);
      repeat (5) @(negedge clock);
      checkOutput("tmo_sticky", {31'b0, timeout_err}, 32'd1);
      hang_en = 1'b0;

      $display("[TB] reset asserted during RUN of bit 5");
      clearLogs();
      applyStimulus(8'h10);
      checkOutput("tmo_cleared", {31'b0, timeout_err}, 32'd0);
      waitEntries(5 * RACES, 5000);
      checkOutput("abort_chal", {24'b0, puf_challenge}, 32'h15);
      reset = 1'b0;
      #1;
      checkOutput("abort_puf_reset", {31'b0, puf_reset}, 32'd1);
      checkOutput("abort_enable", puf_enable, 32'd0);
      checkOutput("abort_busy", {31'b0, busy}, 32'd0);
      checkOutput("abort_resp", {16'b0, response}, 32'd0);
      checkOutput("abort_chal0", {24'b0, puf_challenge}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (400) @(negedge clock);
      checkOutput("abort_no_valid", valid_cnt, 32'd0);
      checkOutput("abort_idle_busy", {31'b0, busy}, 32'd0);

`ifdef PUF_SEQ_MAJORITY_EN
      $display("[TB] majority vote 1,0,1 on challenge 0x10");
      clearLogs();
      maj_en = 1'b1;
      applyStimulus(8'h10);
      waitValid(8000);
      checkOutput("maj_resp", {16'b0, response}, 32'h0000_AAAB);
      checkOutput("maj_clear_phases", run10, 32'd3);
      maj_en = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Initiator-side controller for one PUF parallel subblock: drives its 8-bit challenge, 32-bit ring-oscillator enable and subblock reset, waits for the subblock's race `done`, samples its `out` bit, and assembles RESP_BITS consecutive responses into one response word. It sits between the top-level PUF control logic (or the UART/host front end) and a single subblock instance. It owns the clear/run/capture sequencing and timeout handling, so the subblock itself stays purely datapath.

## Interface
- RESP_BITS, 16: number of challenges evaluated per request, which is also the response word width (1..256).
- CLEAR_CYCLES, 4: cycles `puf_reset` is held high before each race (≥1).
- TIMEOUT_CYCLES, 1048576: maximum cycles in RUN waiting for synchronized done (≥4).
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- challenge_base  in  8  first challenge of the sequence; captured on accepted start.
- puf_out  in  1  subblock race result; asynchronous to `clock`.
- puf_done  in  1  subblock race finished; asynchronous to `clock`.
- puf_challenge  out  8  challenge to subblock.
- puf_enable  out  32  ring-oscillator enables to subblock.
- puf_reset  out  1  active-high reset to subblock counters and arbiter.
- response  out  RESP_BITS  assembled response word.
- resp_valid  out  1  one-cycle pulse when `response` is complete.
- busy  out  1  high from the cycle after an accepted start through the DONE state.
- timeout_err  out  1  sticky; set when any race times out.

## Operation
- States: IDLE, CLEAR, RUN, CAPTURE, DONE.
- IDLE:
  - `start`=1 latches `challenge_base`, clears index `i`, `response` and `timeout_err`, then goes to CLEAR.
  - `start` outside IDLE is ignored.
- CLEAR:
  - `puf_challenge` = `challenge_base + i` (mod 256).
  - `puf_enable` = 0 and `puf_reset` = 1 for exactly CLEAR_CYCLES cycles, then go to RUN.
- RUN:
  - `puf_enable` = 32'hFFFF_FFFF, `puf_reset` = 0, and `puf_challenge` is held.
  - `puf_done` and `puf_out` each pass through a 2-flop synchronizer.
  - Go to CAPTURE on the first cycle synchronized done = 1.
  - Also go to CAPTURE on the cycle the wait counter reaches TIMEOUT_CYCLES-1; this is a timeout.
- CAPTURE (1 cycle):
  - `response[i]` ← synchronized `puf_out`, or 0 on timeout; a timeout also sets `timeout_err`.
  - `puf_enable` = 0.
  - If i == RESP_BITS-1, go to DONE; otherwise increment i and go to CLEAR.
- DONE (1 cycle): `resp_valid` = 1, `puf_reset` = 1, go to IDLE.
- Bit ordering: `response[0]` is the result for `challenge_base`. Challenge wrap from 8'hFF to 8'h00 is legal.
- `response` holds its value after DONE until the next accepted start clears it.
- In IDLE: `puf_reset` = 1, `puf_enable` = 0, and `puf_challenge` holds its last value.

## Timing
- Reset values (async on reset=0):
  - state IDLE, i = 0;
  - `puf_challenge` = 0, `puf_enable` = 0, `puf_reset` = 1;
  - `response` = 0, `resp_valid` = 0, `busy` = 0, `timeout_err` = 0;
  - synchronizers = 0.
- Reset asserted mid-sequence aborts immediately and produces no `resp_valid`.
- Start-to-CLEAR: 1 cycle.
- Per bit: CLEAR_CYCLES + RUN dwell + 1 (CAPTURE). RUN dwell is the done arrival plus 2 synchronizer cycles, bounded by TIMEOUT_CYCLES.
- `resp_valid` is asserted exactly 1 cycle after the last CAPTURE. `busy` deasserts in the cycle after DONE.
- `start` high in the same cycle as DONE is ignored; `start` high in the first IDLE cycle after DONE is accepted.
- Synchronized done still high when entering CLEAR is ignored; it is only examined in RUN.

## Configuration
- `PUF_SEQ_MAJORITY_EN` defined:
  - each challenge is raced 3 times, each race being a full CLEAR+RUN pass;
  - `response[i]` = majority of the 3 bits, where a timed-out race counts as 0;
  - `timeout_err` is set if any race times out;
  - per-bit latency roughly triples.
- Undefined: a single race per challenge, as described above.

## Test plan
- Reset then idle: `puf_reset`=1, `puf_enable`=0, `busy`=0, `response`=0. Assert reset mid-RUN at bit 5: outputs return to reset values next edge and `resp_valid` never pulses.
- RESP_BITS=16, base=8'h10, model returns `out` = challenge[0] with done 20 cycles after enable → challenges 0x10..0x1F in order, `response`=16'hAAAA, one `resp_valid` pulse, `timeout_err`=0.
- base=8'hF8 → challenge sequence 0xF8..0xFF then 0x00..0x07. `puf_reset` is high for exactly 4 cycles before every RUN entry.
- Model never asserts done for bit 3, TIMEOUT_CYCLES=64 → RUN exits after 64 cycles, `response[3]`=0, `timeout_err`=1 until the next start.
- `start` pulsed during RUN and in the DONE cycle → ignored. `start` pulsed in the first IDLE cycle after DONE → new sequence begins and `response` clears.
- `PUF_SEQ_MAJORITY_EN`, model returns 1,0,1 for challenge 0x10 → `response[0]`=1 and exactly 3 CLEAR phases occur for that challenge.
